fir_interpolator: RTL and testbench
===================================

Name: fir_interpolator

Overview:
Time-multiplexed polyphase interpolating FIR: each accepted input sample yields INTERP output samples at INTERP x the input rate. It is the upsampling counterpart of the existing parallel FIR filter and uses the same single-cycle ready-strobe sample protocol on both sides. It uses one multiplier and one accumulator, and steps through coefficients with an FSM instead of a full adder tree.

Parameters:
DATA_IN_BITS, 17, unsigned input sample width
DATA_OUT_BITS, 17, output sample width
FILTER_BITS, 12, unsigned coefficient width
FILTER_TAPS, 32, total prototype taps; must be a multiple of INTERP
INTERP, 4, interpolation factor L (>=2)
PHASE_TAPS, FILTER_TAPS/INTERP, taps per polyphase branch (derived)
PRODUCT_BITS, DATA_IN_BITS+FILTER_BITS, multiplier width (derived)
ACC_BITS, PRODUCT_BITS+$clog2(PHASE_TAPS), accumulator width (derived)

Ports:
clk  in  1  single clock; one clock; reset is asynchronous and active-low
rst  in  1  asynchronous, active-low reset (0 = reset)
data_in_ready  in  1  one-cycle strobe, data_in valid
data_in  in  DATA_IN_BITS  input sample
filter_coefficients  in  FILTER_BITS x FILTER_TAPS  prototype coefficients, quasi-static
data_out_ready  out  1  one-cycle strobe, data_out valid
data_out  out  DATA_OUT_BITS  output sample, held until next strobe
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky; set when a strobe is dropped

Behaviour:
- Reset (rst=0, async): state=IDLE; phase, tap, acc=0; history[0..PHASE_TAPS-1]=0; data_out=0; data_out_ready=0; overrun=0.
- History: hist[0] is the newest sample. On acceptance, hist shifts (hist[i]<=hist[i-1]) and hist[0]<=data_in.
- Phase output: y_p = sum over t=0..PHASE_TAPS-1 of filter_coefficients[t*INTERP+p] * hist[t], for p=0..INTERP-1 in order.
- All arithmetic is unsigned. Products are PRODUCT_BITS wide; acc is ACC_BITS wide, with no wrap inside ACC_BITS.
- data_out = acc[PRODUCT_BITS-1 -: DATA_OUT_BITS] (same scaling as the parallel FIR). Upper acc bits are discarded unless SATURATE_EN is defined.
- FSM states: IDLE, MAC, EMIT.
  - IDLE: on data_in_ready, accept the sample, set phase=0, tap=0, acc=0, go to MAC.
  - MAC: each edge, acc += coef[tap*INTERP+phase]*hist[tap] and tap++. After the edge with tap=PHASE_TAPS-1, go to EMIT.
  - EMIT: register data_out from acc and pulse data_out_ready for exactly one cycle.
    - If phase<INTERP-1: phase++, tap=0, acc=0, go to MAC.
    - Else: go to IDLE. If data_in_ready is also high this cycle, accept it directly (phase=0, go to MAC, no idle bubble).
- Timing: for an input accepted on edge E0, output phase p is registered on edge E0+(p+1)*(PHASE_TAPS+1). The final output lands at E0+INTERP*(PHASE_TAPS+1) (36 with defaults). The minimum input spacing is therefore 36 cycles.
- data_in_ready in MAC, or in EMIT with phase<INTERP-1: the sample is dropped, history is unchanged, overrun<=1, and the computation in flight is unaffected.
- overrun clears only on reset.
- filter_coefficients are sampled every MAC cycle. Changing them mid-sample gives a mixed result; this is legal but undefined numerically.
- Reset asserted mid-MAC: all outputs return to reset values immediately, and no partial output is emitted after release.

Optional Feature:
SATURATE_EN
- Defined: in EMIT, if any acc bit above PRODUCT_BITS-1 is set, data_out = all ones.
- Undefined: plain truncating slice, upper bits ignored.

Decomposition:
- Package fir_pkg holds:
  - the state enum typedef (IDLE, MAC, EMIT);
  - a function for coefficient index (tap*INTERP+phase);
  - a localparam helper for ACC_BITS.
- One natural sub-module is fir_mac_unit: registered multiply-accumulate with a clear input and a 1-cycle accumulate, with the FSM kept in the top module.

Test Plan:
- Impulse: coef[i]=i+1, input 4096 followed by seven inputs of 0, spaced 36 cycles -> 32 outputs read 1,2,3,...,32 in order, then 0s.
- DC: all coef=1024, constant input 4096 -> from the 8th input on, every output = 8192, with strobes exactly 9 cycles apart.
- Overflow, all coef=4095, input 131071 for 8 inputs: without SATURATE_EN data_out=130808 (0x1FEF8); with SATURATE_EN data_out=0x1FFFF.
- Overrun: second strobe 10 cycles after the first -> overrun=1 and stays 1. Outputs equal those of the first sample alone, and busy stays high through E0+36.
- Back-to-back: strobes exactly 36 cycles apart for 20 inputs -> no overrun, 80 outputs, data_out_ready period exactly 9 cycles with no gap.
- Reset mid-MAC: rst low 3 cycles into the MAC phase -> data_out=0, data_out_ready=0, busy=0 asynchronously. A subsequent impulse reproduces the impulse-test outputs (history cleared).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the polyphase interpolating FIR.
package fir_pkg;

  // Controller states: idle, multiply-accumulate over one branch, emit one phase result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } fir_state_e;

  // Prototype coefficient used by branch `phase` at history position `tap`
  function automatic int coef_index(input int tap, input int phase, input int interp);
    return tap * interp + phase;
  endfunction

  // Accumulator width that holds a full branch sum without wrapping
  function automatic int acc_bits_f(input int product_bits, input int phase_taps);
    return product_bits + $clog2(phase_taps);
  endfunction

  localparam int DEF_DATA_IN_BITS  = 17;
  localparam int DEF_FILTER_BITS   = 12;
  localparam int DEF_FILTER_TAPS   = 32;
  localparam int DEF_INTERP        = 4;
  localparam int DEF_ACC_BITS      = acc_bits_f(DEF_DATA_IN_BITS + DEF_FILTER_BITS,
                                                DEF_FILTER_TAPS / DEF_INTERP);

endpackage

// File: rtl/fir_mac_unit.sv
// Registered multiply-accumulate with synchronous clear and output scaling.
// Optional macro SATURATE_EN: clamp the scaled output to all ones when any
// accumulator bit above the product width is set.
module fir_mac_unit #(
  parameter int A_BITS   = 17,
  parameter int B_BITS   = 12,
  parameter int ACC_BITS = 32,
  parameter int OUT_BITS = 17
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [A_BITS-1:0]   a_i,
  input  logic [B_BITS-1:0]   b_i,
  output logic [OUT_BITS-1:0] result_o
);

  localparam int PROD_BITS = A_BITS + B_BITS;

  logic [PROD_BITS-1:0] prod;
  logic [ACC_BITS-1:0]  acc_q;
  logic [ACC_BITS-1:0]  acc_d;

  // Both operands widened so the product is computed at full width
  assign prod = {{B_BITS{1'b0}}, a_i} * {{A_BITS{1'b0}}, b_i};

  // Next accumulator: clear wins over accumulate
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_BITS'(prod);
    end
  end

  // Accumulator register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef SATURATE_EN
  assign result_o = (|acc_q[ACC_BITS-1:PROD_BITS]) ? {OUT_BITS{1'b1}}
                                                   : acc_q[PROD_BITS-1 -: OUT_BITS];
`else
  assign result_o = acc_q[PROD_BITS-1 -: OUT_BITS];
`endif

endmodule

// File: rtl/fir_interpolator.sv
// Time-multiplexed polyphase interpolating FIR: one multiplier, one
// accumulator, INTERP outputs per accepted input sample.
// Optional macro SATURATE_EN (handled in fir_mac_unit): saturate outputs
// whose branch sum exceeds the product width.
//
// state | meaning
// IDLE  | waiting for an input strobe
// MAC   | accumulating one polyphase branch, one tap per cycle
// EMIT  | registering the branch result; next phase or next sample
module fir_interpolator
  import fir_pkg::*;
#(
  parameter int DATA_IN_BITS  = 17,
  parameter int DATA_OUT_BITS = 17,
  parameter int FILTER_BITS   = 12,
  parameter int FILTER_TAPS   = 32,
  parameter int INTERP        = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    data_in_ready_i,
  input  logic [DATA_IN_BITS-1:0]                 data_in_i,
  input  logic [FILTER_TAPS-1:0][FILTER_BITS-1:0] filter_coefficients_i,
  output logic                                    data_out_ready_o,
  output logic [DATA_OUT_BITS-1:0]                data_out_o,
  output logic                                    busy_o,
  output logic                                    overrun_o
);

  localparam int PHASE_TAPS   = FILTER_TAPS / INTERP;
  localparam int PRODUCT_BITS = DATA_IN_BITS + FILTER_BITS;
  localparam int ACC_BITS     = acc_bits_f(PRODUCT_BITS, PHASE_TAPS);
  localparam int TAP_W        = (PHASE_TAPS > 1) ? $clog2(PHASE_TAPS) : 1;
  localparam int PH_W         = $clog2(INTERP);
  localparam int CIDX_W       = $clog2(FILTER_TAPS);

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(PHASE_TAPS - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(INTERP - 1);

  fir_state_e                state_q;
  logic [PH_W-1:0]           phase_q;
  logic [TAP_W-1:0]          tap_q;
  logic [DATA_IN_BITS-1:0]   hist_q     [PHASE_TAPS];
  logic [DATA_IN_BITS-1:0]   hist_d     [PHASE_TAPS];
  logic [DATA_OUT_BITS-1:0]  data_out_q;
  logic                      data_out_ready_q;
  logic                      overrun_q;

  logic                      accept;
  logic                      drop;
  logic [CIDX_W-1:0]         cidx;
  logic [FILTER_BITS-1:0]    coef_sel;
  logic [DATA_IN_BITS-1:0]   hist_sel;
  logic                      mac_clr;
  logic                      mac_en;
  logic [DATA_OUT_BITS-1:0]  mac_result;

  // A strobe is taken in IDLE or on the last EMIT; anywhere else it is lost
  assign accept = data_in_ready_i &&
                  ((state_q == IDLE) || ((state_q == EMIT) && (phase_q == PH_LAST)));
  assign drop   = data_in_ready_i && !accept;

  assign cidx     = CIDX_W'(coef_index(int'(tap_q), int'(phase_q), INTERP));
  assign coef_sel = filter_coefficients_i[cidx];
  assign hist_sel = hist_q[tap_q];

  // Accumulator only runs during MAC; every other state leaves it cleared
  assign mac_en  = (state_q == MAC);
  assign mac_clr = (state_q != MAC);

  // History as it looks after accepting data_in_i (newest at index 0)
  always_comb begin
    hist_d[0] = data_in_i;
    for (int i = 1; i < PHASE_TAPS; i++) begin
      hist_d[i] = hist_q[i-1];
    end
  end

  fir_mac_unit #(
    .A_BITS   (DATA_IN_BITS),
    .B_BITS   (FILTER_BITS),
    .ACC_BITS (ACC_BITS),
    .OUT_BITS (DATA_OUT_BITS)
  ) u_mac (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (mac_clr),
    .en_i     (mac_en),
    .a_i      (hist_sel),
    .b_i      (coef_sel),
    .result_o (mac_result)
  );

  // Sequencer: walks taps then phases, owns history, output and overrun flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      phase_q          <= '0;
      tap_q            <= '0;
      data_out_q       <= '0;
      data_out_ready_q <= 1'b0;
      overrun_q        <= 1'b0;
      for (int i = 0; i < PHASE_TAPS; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      data_out_ready_q <= 1'b0;
      if (drop) begin
        overrun_q <= 1'b1;
      end
      if (accept) begin
        hist_q <= hist_d;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            phase_q <= '0;
            tap_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (tap_q == TAP_LAST) begin
            tap_q   <= '0;
            state_q <= EMIT;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        EMIT: begin
          data_out_q       <= mac_result;
          data_out_ready_q <= 1'b1;
          tap_q            <= '0;
          if (phase_q != PH_LAST) begin
            phase_q <= phase_q + 1'b1;
            state_q <= MAC;
          end else if (accept) begin
            // next sample starts without an idle bubble
            phase_q <= '0;
            state_q <= MAC;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out_o       = data_out_q;
  assign data_out_ready_o = data_out_ready_q;
  assign overrun_o        = overrun_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_fir_interpolator.sv
// Scoreboard bench for fir_interpolator (default parameters).
module tb_fir_interpolator;

  localparam int DIN  = 17;
  localparam int DOUT = 17;
  localparam int FB   = 12;
  localparam int TAPS = 32;
  localparam int L    = 4;
  localparam int PT   = TAPS / L;

  logic                      clk = 1'b0;
  logic                      rst_ni = 1'b0;
  logic                      din_rdy = 1'b0;
  logic [DIN-1:0]            din = '0;
  logic [TAPS-1:0][FB-1:0]   coef = '0;
  logic                      dout_rdy;
  logic [DOUT-1:0]           dout;
  logic                      busy;
  logic                      overrun;

  fir_interpolator dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .data_in_ready_i       (din_rdy),
    .data_in_i             (din),
    .filter_coefficients_i (coef),
    .data_out_ready_o      (dout_rdy),
    .data_out_o            (dout),
    .busy_o                (busy),
    .overrun_o             (overrun)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  longint      cyc = 0;
  longint      last_strobe = -1;
  bit          per_chk = 1'b0;
  int          n_out = 0;
  logic [DOUT-1:0] exp_q[$];
  logic [DOUT-1:0] exp_v;
  longint      coef_m [TAPS];
  longint      model_hist [PT];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [DOUT-1:0] model_out(input int p);
    longint s = 0;
    for (int t = 0; t < PT; t++) s += coef_m[t*L+p] * model_hist[t];
`ifdef SATURATE_EN
    if ((s >> (DIN + FB)) != 0) return {DOUT{1'b1}};
`endif
    return DOUT'((s >> (DIN + FB - DOUT)) & ((64'd1 << DOUT) - 1));
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_ni && dout_rdy) begin
      n_out++;
      if (per_chk && last_strobe >= 0) chk("strobe_period", cyc - last_strobe, 9);
      last_strobe = cyc;
      if (exp_q.size() == 0) chk("spurious_strobe", dout_rdy, 0);
      else begin
        exp_v = exp_q.pop_front();
        chk("data_out", dout, exp_v);
      end
    end
  end

  task automatic set_coef(input int mode);
    for (int i = 0; i < TAPS; i++) begin
      case (mode)
        0:       coef_m[i] = i + 1;
        1:       coef_m[i] = 1024;
        2:       coef_m[i] = 4095;
        default: coef_m[i] = $urandom_range(4095);
      endcase
      coef[i] = FB'(coef_m[i]);
    end
  endtask

  task automatic clear_model();
    for (int t = 0; t < PT; t++) model_hist[t] = 0;
  endtask

  // one-cycle strobe; returns at the negedge right after the acceptance edge
  task automatic send(input logic [DIN-1:0] x);
    @(negedge clk);
    din = x;
    din_rdy = 1'b1;
    for (int t = PT - 1; t > 0; t--) model_hist[t] = model_hist[t-1];
    model_hist[0] = longint'(x);
    for (int p = 0; p < L; p++) exp_q.push_back(model_out(p));
    @(negedge clk);
    din_rdy = 1'b0;
  endtask

  task automatic send_spaced(input logic [DIN-1:0] x);
    send(x);
    repeat (34) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (12) @(negedge clk);
    per_chk = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit all_busy;
    clear_model();
    set_coef(0);
    #1;
    chk("rst_data_out", dout, 0);
    chk("rst_ready", dout_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    repeat (4) @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // impulse: outputs walk through the coefficient ramp 1..32
    n_out = 0;
    send_spaced(17'd4096);
    for (int k = 0; k < 7; k++) send_spaced(17'd0);
    wait_drain("impulse_drain");
    chk("impulse_count", n_out, 32);

    // DC: steady state 8192, strobes 9 cycles apart
    set_coef(1);
    n_out = 0; last_strobe = -1; per_chk = 1'b1;
    for (int k = 0; k < 12; k++) send_spaced(17'd4096);
    wait_drain("dc_drain");
    chk("dc_count", n_out, 48);
    chk("dc_value", dout, 8192);

    // overflow of the product-width window
    set_coef(2);
    for (int k = 0; k < 8; k++) send_spaced(17'd131071);
    wait_drain("ovf_drain");
`ifdef SATURATE_EN
    chk("ovf_value", dout, 17'h1FFFF);
`else
    chk("ovf_value", dout, 130808);
`endif

    // back-to-back at the minimum spacing
    set_coef(3);
    n_out = 0; last_strobe = -1; per_chk = 1'b1;
    for (int k = 0; k < 20; k++) send_spaced(DIN'($urandom_range(131071)));
    wait_drain("b2b_drain");
    chk("b2b_count", n_out, 80);
    chk("b2b_overrun", overrun, 0);

    // overrun: second strobe 10 cycles after the first is dropped
    set_coef(0);
    n_out = 0;
    send(DIN'($urandom_range(1, 131071)));
    all_busy = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (!busy) all_busy = 1'b0;
      din_rdy = (i == 9);
      din = DIN'($urandom_range(131071));
    end
    chk("ovr_flag", overrun, 1);
    chk("ovr_busy_through", all_busy, 1);
    wait_drain("ovr_drain");
    chk("ovr_count", n_out, 4);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_idle", busy, 0);

    // reset three cycles into MAC
    send(17'd4096);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("mid_rst_data_out", dout, 0);
    chk("mid_rst_ready", dout_rdy, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    exp_q.delete();
    clear_model();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    n_out = 0;
    repeat (40) @(negedge clk);
    chk("post_rst_quiet", n_out, 0);
    send_spaced(17'd4096);
    for (int k = 0; k < 7; k++) send_spaced(17'd0);
    wait_drain("impulse2_drain");
    chk("impulse2_count", n_out, 32);
    chk("impulse2_last", dout, 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
